// File: rtl/way_age_tracker.sv
// way_age_tracker
// Per-set age-ordering store for the cache's max-age victim selector. Each set holds a
// permutation of ages 0..NUM_WAY-1 (0 = most recently used, NUM_WAY-1 = victim candidate).
// Access and invalidate requests reorder one set per cycle by read-modify-write. A lookup
// returns the full age vector of a set one cycle after acceptance.
//
// Ports:
//   clk_in                single clock, rising edge
//   reset_in              synchronous active-high reset, restarts the init sweep
//   access_*              touch request (hit or fill); ready is high whenever initialised
//   invalidate_*          invalidate request; stalls while an access is presented
//   lookup_valid_in/set   age read request, accepted alongside access_ready_out
//   lookup_valid_out      one-cycle pulse per accepted lookup
//   lookup_ages_out       flattened ages, way i at [i*W +: W]; held between lookups
//   init_done_out         high once every set has been initialised
module way_age_tracker #(
  parameter int unsigned NUM_WAY                  = 16,
  parameter int unsigned NUM_SET                  = 64,
  parameter int unsigned SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int unsigned WAY_PTR_WIDTH_IN_BITS    = $clog2(NUM_WAY) + 1,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS    = $clog2(NUM_SET)
) (
  input  logic                                         clk_in,
  input  logic                                         reset_in,
  input  logic                                         access_valid_in,
  output logic                                         access_ready_out,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]             access_set_in,
  input  logic [WAY_PTR_WIDTH_IN_BITS-1:0]             access_way_in,
  input  logic                                         invalidate_valid_in,
  output logic                                         invalidate_ready_out,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]             invalidate_set_in,
  input  logic [WAY_PTR_WIDTH_IN_BITS-1:0]             invalidate_way_in,
  input  logic                                         lookup_valid_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]             lookup_set_in,
  output logic                                         lookup_valid_out,
  output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]  lookup_ages_out,
  output logic                                         init_done_out
);

  localparam int unsigned W  = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int unsigned WP = WAY_PTR_WIDTH_IN_BITS;
  localparam int unsigned SP = SET_PTR_WIDTH_IN_BITS;

  localparam logic [W-1:0]  MaxAge  = W'(NUM_WAY - 1);
  localparam logic [SP-1:0] LastSet = SP'(NUM_SET - 1);

  typedef logic [NUM_WAY-1:0][W-1:0] row_t;

  typedef enum logic [0:0] {
    StInit,
    StReady
  } state_e;

  // Reset ordering: way i has age i.
  function automatic row_t init_row();
    row_t res;
    for (int i = 0; i < NUM_WAY; i++) begin
      res[i] = W'(i);
    end
    return res;
  endfunction

  // Promote a way to age 0; ways younger than it age by one. Out-of-range way is a no-op.
  function automatic row_t touch_row(row_t row, logic [WP-1:0] way);
    row_t       res;
    logic [W-1:0] old_age;
    logic       hit;
    res     = row;
    old_age = '0;
    hit     = 1'b0;
    for (int i = 0; i < NUM_WAY; i++) begin
      if (way == WP'(i)) begin
        old_age = row[i];
        hit     = 1'b1;
      end
    end
    if (hit) begin
      for (int i = 0; i < NUM_WAY; i++) begin
        if (way == WP'(i)) begin
          res[i] = '0;
        end else if (row[i] < old_age) begin
          res[i] = row[i] + 1'b1;
        end
      end
    end
    return res;
  endfunction

  // Demote a way to the oldest age; ways older than it get one step younger.
  function automatic row_t invalidate_row(row_t row, logic [WP-1:0] way);
    row_t       res;
    logic [W-1:0] old_age;
    logic       hit;
    res     = row;
    old_age = '0;
    hit     = 1'b0;
    for (int i = 0; i < NUM_WAY; i++) begin
      if (way == WP'(i)) begin
        old_age = row[i];
        hit     = 1'b1;
      end
    end
    if (hit) begin
      for (int i = 0; i < NUM_WAY; i++) begin
        if (way == WP'(i)) begin
          res[i] = MaxAge;
        end else if (row[i] > old_age) begin
          res[i] = row[i] - 1'b1;
        end
      end
    end
    return res;
  endfunction

  state_e        state_q, state_d;
  logic [SP-1:0] cnt_q, cnt_d;
  logic          lookup_valid_q, lookup_valid_d;
  row_t          lookup_ages_q, lookup_ages_d;

  // Age storage is not reset; the init sweep rewrites every set.
  row_t          mem_q [NUM_SET];

  logic          wr_en;
  logic [SP-1:0] wr_set;
  row_t          wr_row;

  logic          ready;
  logic          access_fire;
  logic          invalidate_fire;
  logic          lookup_fire;
  row_t          access_row;
  row_t          invalidate_new_row;

  assign ready           = (state_q == StReady);
  assign access_fire     = ready & access_valid_in;
  assign invalidate_fire = ready & invalidate_valid_in & ~access_valid_in;
  assign lookup_fire     = ready & lookup_valid_in;

  assign access_row         = touch_row(mem_q[access_set_in], access_way_in);
  assign invalidate_new_row = invalidate_row(mem_q[invalidate_set_in], invalidate_way_in);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    wr_en          = 1'b0;
    wr_set         = '0;
    wr_row         = '0;
    lookup_valid_d = lookup_fire;
    lookup_ages_d  = lookup_ages_q;

    unique case (state_q)
      StInit: begin
        wr_en  = 1'b1;
        wr_set = cnt_q;
        wr_row = init_row();
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastSet) begin
          state_d = StReady;
          cnt_d   = '0;
        end
      end
      StReady: begin
        // Access and invalidate never write in the same cycle: invalidate stalls on access.
        if (access_fire) begin
          wr_en  = 1'b1;
          wr_set = access_set_in;
          wr_row = access_row;
        end else if (invalidate_fire) begin
          wr_en  = 1'b1;
          wr_set = invalidate_set_in;
          wr_row = invalidate_new_row;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase

    if (lookup_fire) begin
      // Same-cycle access to the looked-up set is forwarded so the result is post-update.
      if (access_fire && (access_set_in == lookup_set_in)) begin
        lookup_ages_d = access_row;
      end else begin
        lookup_ages_d = mem_q[lookup_set_in];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q        <= StInit;
      cnt_q          <= '0;
      lookup_valid_q <= 1'b0;
      lookup_ages_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lookup_valid_q <= lookup_valid_d;
      lookup_ages_q  <= lookup_ages_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in && wr_en) begin
      mem_q[wr_set] <= wr_row;
    end
  end

  assign access_ready_out     = ready;
  assign invalidate_ready_out = ready & ~access_valid_in;
  assign init_done_out        = ready;
  assign lookup_valid_out     = lookup_valid_q;
  assign lookup_ages_out      = lookup_ages_q;

endmodule

// File: tb/tb_way_age_tracker.sv
// Directed bench for way_age_tracker with 4 ways, 4 sets, 2-bit ages.
module tb_way_age_tracker;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       access_valid_in;
  logic       access_ready_out;
  logic [1:0] access_set_in;
  logic [2:0] access_way_in;
  logic       invalidate_valid_in;
  logic       invalidate_ready_out;
  logic [1:0] invalidate_set_in;
  logic [2:0] invalidate_way_in;
  logic       lookup_valid_in;
  logic [1:0] lookup_set_in;
  logic       lookup_valid_out;
  logic [7:0] lookup_ages_out;
  logic       init_done_out;

  int errors = 0;
  int checks = 0;

  way_age_tracker #(
    .NUM_WAY                  (4),
    .NUM_SET                  (4),
    .SINGLE_WAY_WIDTH_IN_BITS (2),
    .WAY_PTR_WIDTH_IN_BITS    (3),
    .SET_PTR_WIDTH_IN_BITS    (2)
  ) dut (
    .clk_in               (clk_in),
    .reset_in             (reset_in),
    .access_valid_in      (access_valid_in),
    .access_ready_out     (access_ready_out),
    .access_set_in        (access_set_in),
    .access_way_in        (access_way_in),
    .invalidate_valid_in  (invalidate_valid_in),
    .invalidate_ready_out (invalidate_ready_out),
    .invalidate_set_in    (invalidate_set_in),
    .invalidate_way_in    (invalidate_way_in),
    .lookup_valid_in      (lookup_valid_in),
    .lookup_set_in        (lookup_set_in),
    .lookup_valid_out     (lookup_valid_out),
    .lookup_ages_out      (lookup_ages_out),
    .init_done_out        (init_done_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Issue one lookup and return what the DUT presents on the following cycle.
  task automatic lookup(input logic [1:0] s, output logic [7:0] ages, output logic vld);
    lookup_valid_in = 1'b1;
    lookup_set_in   = s;
    step();
    lookup_valid_in = 1'b0;
    vld  = lookup_valid_out;
    ages = lookup_ages_out;
  endtask

  task automatic access(input logic [1:0] s, input logic [2:0] w);
    access_valid_in = 1'b1;
    access_set_in   = s;
    access_way_in   = w;
    step();
    access_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] ages;
    logic       vld;
    reset_in = 1'b1;
    repeat (3) step();
    checks++; if (access_ready_out !== 1'b0) begin errors++;
      $display("FAIL rst_acc_ready: got %b expected 0", access_ready_out); end
    checks++; if (invalidate_ready_out !== 1'b0) begin errors++;
      $display("FAIL rst_inv_ready: got %b expected 0", invalidate_ready_out); end
    checks++; if (lookup_valid_out !== 1'b0) begin errors++;
      $display("FAIL rst_lkp_valid: got %b expected 0", lookup_valid_out); end
    checks++; if (lookup_ages_out !== 8'h00) begin errors++;
      $display("FAIL rst_lkp_ages: got %h expected 00", lookup_ages_out); end
    checks++; if (init_done_out !== 1'b0) begin errors++;
      $display("FAIL rst_init_done: got %b expected 0", init_done_out); end
    reset_in        = 1'b0;
    lookup_valid_in = 1'b1;
    lookup_set_in   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (init_done_out !== (k == 4)) begin errors++;
        $display("FAIL init_done_c%0d: got %b expected %b", k, init_done_out, (k == 4)); end
      checks++; if (access_ready_out !== (k == 4)) begin errors++;
        $display("FAIL init_acc_ready_c%0d: got %b expected %b", k, access_ready_out, (k == 4)); end
      checks++; if (invalidate_ready_out !== (k == 4)) begin errors++;
        $display("FAIL init_inv_ready_c%0d: got %b expected %b", k, invalidate_ready_out,
                 (k == 4)); end
      checks++; if (lookup_valid_out !== 1'b0) begin errors++;
        $display("FAIL init_lkp_ignored_c%0d: got %b expected 0", k, lookup_valid_out); end
    end
    lookup_valid_in = 1'b0;
    for (int s = 0; s < 4; s++) begin
      lookup(2'(s), ages, vld);
      checks++; if (vld !== 1'b1 || ages !== 8'hE4) begin errors++;
        $display("FAIL init_set%0d: got valid=%b ages=%h expected valid=1 ages=e4", s, vld, ages); end
    end
  endtask

  task automatic test_access();
    logic [7:0] ages;
    logic       vld;
    access(2'd1, 3'd2);
    lookup(2'd1, ages, vld);
    checks++; if (vld !== 1'b1 || ages !== 8'hC9) begin errors++;
      $display("FAIL access_s1w2: got valid=%b ages=%h expected valid=1 ages=c9", vld, ages); end
    for (int s = 0; s < 4; s++) begin
      if (s != 1) begin
        lookup(2'(s), ages, vld);
        checks++; if (ages !== 8'hE4) begin errors++;
          $display("FAIL access_other_set%0d: got %h expected e4", s, ages); end
      end
    end
  endtask

  task automatic test_invalidate();
    logic [7:0] ages;
    logic       vld;
    invalidate_valid_in = 1'b1;
    invalidate_set_in   = 2'd1;
    invalidate_way_in   = 3'd0;
    #1;
    checks++; if (invalidate_ready_out !== 1'b1) begin errors++;
      $display("FAIL inv_ready: got %b expected 1", invalidate_ready_out); end
    step();
    invalidate_valid_in = 1'b0;
    lookup(2'd1, ages, vld);
    checks++; if (vld !== 1'b1 || ages !== 8'h87) begin errors++;
      $display("FAIL inv_s1w0: got valid=%b ages=%h expected valid=1 ages=87", vld, ages); end
  endtask

  task automatic test_forward();
    logic [7:0] ages;
    logic       vld;
    // Access and lookup of set 3 in the same cycle.
    access_valid_in = 1'b1; access_set_in = 2'd3; access_way_in = 3'd3;
    lookup_valid_in = 1'b1; lookup_set_in = 2'd3;
    step();
    access_valid_in = 1'b0; lookup_valid_in = 1'b0;
    checks++; if (lookup_valid_out !== 1'b1 || lookup_ages_out !== 8'h39) begin errors++;
      $display("FAIL fwd_s3w3: got valid=%b ages=%h expected valid=1 ages=39",
               lookup_valid_out, lookup_ages_out); end
    lookup(2'd3, ages, vld);
    checks++; if (ages !== 8'h39) begin errors++;
      $display("FAIL fwd_s3_stored: got %h expected 39", ages); end
    // Age-0 way access leaves the set unchanged.
    access_valid_in = 1'b1; access_set_in = 2'd0; access_way_in = 3'd0;
    lookup_valid_in = 1'b1; lookup_set_in = 2'd0;
    step();
    access_valid_in = 1'b0; lookup_valid_in = 1'b0;
    checks++; if (lookup_ages_out !== 8'hE4) begin errors++;
      $display("FAIL fwd_age0_s0: got %h expected e4", lookup_ages_out); end
    access(2'd3, 3'd3);
    lookup(2'd3, ages, vld);
    checks++; if (ages !== 8'h39) begin errors++;
      $display("FAIL fwd_age0_s3: got %h expected 39", ages); end
    // Access to set 3 must not leak into a lookup of set 2.
    access_valid_in = 1'b1; access_set_in = 2'd3; access_way_in = 3'd0;
    lookup_valid_in = 1'b1; lookup_set_in = 2'd2;
    step();
    access_valid_in = 1'b0; lookup_valid_in = 1'b0;
    checks++; if (lookup_ages_out !== 8'hE4) begin errors++;
      $display("FAIL fwd_other_set: got %h expected e4", lookup_ages_out); end
    lookup(2'd3, ages, vld);
    checks++; if (ages !== 8'h78) begin errors++;
      $display("FAIL fwd_s3w0: got %h expected 78", ages); end
  endtask

  task automatic test_back_to_back();
    // set 1 is 0x87 here
    access_valid_in = 1'b1; access_set_in = 2'd1; access_way_in = 3'd3;
    step();
    access_way_in   = 3'd0;
    lookup_valid_in = 1'b1; lookup_set_in = 2'd1;
    step();
    access_valid_in = 1'b0;
    checks++; if (lookup_valid_out !== 1'b1 || lookup_ages_out !== 8'h6C) begin errors++;
      $display("FAIL b2b_fwd: got valid=%b ages=%h expected valid=1 ages=6c",
               lookup_valid_out, lookup_ages_out); end
    step();
    lookup_set_in = 2'd2;
    checks++; if (lookup_valid_out !== 1'b1 || lookup_ages_out !== 8'h6C) begin errors++;
      $display("FAIL b2b_stored: got valid=%b ages=%h expected valid=1 ages=6c",
               lookup_valid_out, lookup_ages_out); end
    step();
    lookup_valid_in = 1'b0;
    checks++; if (lookup_valid_out !== 1'b1 || lookup_ages_out !== 8'hE4) begin errors++;
      $display("FAIL b2b_set2: got valid=%b ages=%h expected valid=1 ages=e4",
               lookup_valid_out, lookup_ages_out); end
    step();
    checks++; if (lookup_valid_out !== 1'b0 || lookup_ages_out !== 8'hE4) begin errors++;
      $display("FAIL b2b_hold: got valid=%b ages=%h expected valid=0 ages=e4",
               lookup_valid_out, lookup_ages_out); end
  endtask

  task automatic test_priority();
    logic [7:0] ages;
    logic       vld;
    access_valid_in     = 1'b1; access_set_in     = 2'd2; access_way_in     = 3'd1;
    invalidate_valid_in = 1'b1; invalidate_set_in = 2'd0; invalidate_way_in = 3'd1;
    #1;
    checks++; if (invalidate_ready_out !== 1'b0 || access_ready_out !== 1'b1) begin errors++;
      $display("FAIL prio_ready: got acc=%b inv=%b expected acc=1 inv=0",
               access_ready_out, invalidate_ready_out); end
    step();
    access_valid_in = 1'b0;
    lookup_valid_in = 1'b1; lookup_set_in = 2'd2;
    #1;
    checks++; if (invalidate_ready_out !== 1'b1) begin errors++;
      $display("FAIL prio_inv_retry: got %b expected 1", invalidate_ready_out); end
    step();
    invalidate_valid_in = 1'b0; lookup_valid_in = 1'b0;
    checks++; if (lookup_ages_out !== 8'hE1) begin errors++;
      $display("FAIL prio_access_s2: got %h expected e1", lookup_ages_out); end
    lookup(2'd0, ages, vld);
    checks++; if (ages !== 8'h9C) begin errors++;
      $display("FAIL prio_inv_s0: got %h expected 9c", ages); end
    // Out-of-range way: handshake completes, set unchanged.
    access_valid_in = 1'b1; access_set_in = 2'd2; access_way_in = 3'd4;
    #1;
    checks++; if (access_ready_out !== 1'b1) begin errors++;
      $display("FAIL oor_acc_ready: got %b expected 1", access_ready_out); end
    step();
    access_valid_in     = 1'b0;
    invalidate_valid_in = 1'b1; invalidate_set_in = 2'd2; invalidate_way_in = 3'd4;
    #1;
    checks++; if (invalidate_ready_out !== 1'b1) begin errors++;
      $display("FAIL oor_inv_ready: got %b expected 1", invalidate_ready_out); end
    step();
    invalidate_valid_in = 1'b0;
    lookup(2'd2, ages, vld);
    checks++; if (ages !== 8'hE1) begin errors++;
      $display("FAIL oor_s2: got %h expected e1", ages); end
  endtask

  task automatic test_reset_midway();
    logic [7:0] ages;
    logic       vld;
    // Reset after updates, with lookup_ages_out nonzero.
    reset_in = 1'b1;
    step();
    checks++; if (lookup_ages_out !== 8'h00 || lookup_valid_out !== 1'b0 ||
                  init_done_out !== 1'b0 || access_ready_out !== 1'b0 ||
                  invalidate_ready_out !== 1'b0) begin errors++;
      $display("FAIL rst2_outputs: got ages=%h lv=%b done=%b ar=%b ir=%b expected all 0",
               lookup_ages_out, lookup_valid_out, init_done_out, access_ready_out,
               invalidate_ready_out); end
    // Reset again part-way through the sweep.
    reset_in = 1'b0;
    repeat (2) step();
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (init_done_out !== (k == 4)) begin errors++;
        $display("FAIL reinit_done_c%0d: got %b expected %b", k, init_done_out, (k == 4)); end
    end
    for (int s = 0; s < 4; s++) begin
      lookup(2'(s), ages, vld);
      checks++; if (vld !== 1'b1 || ages !== 8'hE4) begin errors++;
        $display("FAIL reinit_set%0d: got valid=%b ages=%h expected valid=1 ages=e4",
                 s, vld, ages); end
    end
  endtask

  initial begin
    reset_in            = 1'b1;
    access_valid_in     = 1'b0;
    access_set_in       = '0;
    access_way_in       = '0;
    invalidate_valid_in = 1'b0;
    invalidate_set_in   = '0;
    invalidate_way_in   = '0;
    lookup_valid_in     = 1'b0;
    lookup_set_in       = '0;
    #1;
    test_reset();
    test_access();
    test_invalidate();
    test_forward();
    test_back_to_back();
    test_priority();
    test_reset_midway();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
